decode_stage: RTL and testbench

Registered instruction-decode stage for the 5-stage LEGv8 pipeline, between fetch and execute. It is the next generation of the combinational instruction adapter. It accepts one 32-bit instruction per valid/ready handshake and decodes it into register indices, control flags, a sign-extended immediate and a branch offset at parametrised datapath width. It holds the result in an output register with backpressure, detects load-use hazards and inserts one bubble, and supports pipeline flush.

---
 rtl/decode_stage_if.sv | 52 +++++
 rtl/decode_stage.sv | 185 ++++++++++++++++++
 tb/tb_decode_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
//------------------------------------------------------------------------------
// decode_stage_if
// Fetch-side and execute-side handshake bundle for the LEGv8 decode stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface decode_stage_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rd;
    logic [4:0]      rn;
    logic [4:0]      rm;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            set_flags;
    logic [2:0]      alu_op;
    logic            uncond_br;
    logic            br_zero;
    logic            br_cond;
    logic [3:0]      cond;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] br_offset;
    logic            illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rd, rn, rm, reg_write, mem_write,
               mem_to_reg, alu_src, set_flags, alu_op, uncond_br, br_zero,
               br_cond, cond, imm, br_offset, illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rd, rn, rm, reg_write, mem_write,
               mem_to_reg, alu_src, set_flags, alu_op, uncond_br, br_zero,
               br_cond, cond, imm, br_offset, illegal
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// decode_stage
// Registered LEGv8 decode stage with backpressure, load-use bubble and flush.
// Optional feature macro: DECODE_MUL_EN (decode MUL as a legal instruction).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    decode_stage_if.slave bus
);
    localparam logic [9:0]  c_op_addi = 10'b1001000100;
    localparam logic [10:0] c_op_adds = 11'b10101011000;
    localparam logic [10:0] c_op_subs = 11'b11101011000;
    localparam logic [10:0] c_op_lsl  = 11'b11010011011;
    localparam logic [10:0] c_op_lsr  = 11'b11010011010;
    localparam logic [10:0] c_op_mul  = 11'b10011011000;
    localparam logic [10:0] c_op_ldur = 11'b11111000010;
    localparam logic [10:0] c_op_stur = 11'b11111000000;
    localparam logic [5:0]  c_op_b    = 6'b000101;
    localparam logic [7:0]  c_op_bc   = 8'b01010100;
    localparam logic [7:0]  c_op_cbz  = 8'b10110100;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b011;
    localparam logic [2:0] c_alu_lsl = 3'b101;
    localparam logic [2:0] c_alu_lsr = 3'b110;
`ifdef DECODE_MUL_EN
    localparam logic [2:0] c_alu_mul = 3'b111;
`endif

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rn;
        logic [4:0]      rm;
        logic            reg_write;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            set_flags;
        logic [2:0]      alu_op;
        logic            uncond_br;
        logic            br_zero;
        logic            br_cond;
        logic [3:0]      cond;
        logic            illegal;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] br_offset;
    } dec_t;

    dec_t            w_dec;
    dec_t            r_dec;
    logic            w_use_rn;
    logic            w_use_rm;
    logic            w_is_ldur;
    logic            w_hazard;
    logic            w_accept;
    logic            w_in_ready;
    logic            r_valid;
    logic            r_is_ldur;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     w_instr;
    logic [10:0]     w_op11;

    assign w_instr = bus.in_instr;
    assign w_op11  = w_instr[31:21];

    always_comb begin
        w_dec        = '0;
        w_dec.rd     = w_instr[4:0];
        w_dec.rn     = w_instr[9:5];
        w_dec.rm     = w_instr[20:16];
        w_use_rn     = 1'b0;
        w_use_rm     = 1'b0;
        w_is_ldur    = 1'b0;
        if (w_instr[31:22] == c_op_addi) begin
            w_dec.imm       = {{(XLEN-12){1'b0}}, w_instr[21:10]};
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = c_alu_add;
            w_dec.reg_write = 1'b1;
            w_use_rn        = 1'b1;
        end else if (w_op11 == c_op_adds || w_op11 == c_op_subs) begin
            w_dec.alu_op    = (w_op11 == c_op_adds) ? c_alu_add : c_alu_sub;
            w_dec.set_flags = 1'b1;
            w_dec.reg_write = 1'b1;
            w_use_rn        = 1'b1;
            w_use_rm        = 1'b1;
        end else if (w_op11 == c_op_lsl || w_op11 == c_op_lsr) begin
            w_dec.imm       = {{(XLEN-6){1'b0}}, w_instr[15:10]};
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = (w_op11 == c_op_lsl) ? c_alu_lsl : c_alu_lsr;
            w_dec.reg_write = 1'b1;
            w_use_rn        = 1'b1;
`ifdef DECODE_MUL_EN
        end else if (w_op11 == c_op_mul) begin
            w_dec.alu_op    = c_alu_mul;
            w_dec.reg_write = 1'b1;
            w_use_rn        = 1'b1;
            w_use_rm        = 1'b1;
`endif
        end else if (w_op11 == c_op_ldur || w_op11 == c_op_stur) begin
            w_dec.imm     = {{(XLEN-9){w_instr[20]}}, w_instr[20:12]};
            w_dec.alu_src = 1'b1;
            w_dec.alu_op  = c_alu_add;
            w_use_rn      = 1'b1;
            if (w_op11 == c_op_ldur) begin
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_is_ldur        = 1'b1;
            end else begin
                // Stores carry the data register Rt in the second-source slot
                w_dec.mem_write = 1'b1;
                w_dec.rm        = w_instr[4:0];
                w_use_rm        = 1'b1;
            end
        end else if (w_instr[31:26] == c_op_b) begin
            w_dec.uncond_br = 1'b1;
            w_dec.br_offset = {{(XLEN-28){w_instr[25]}}, w_instr[25:0], 2'b00};
        end else if (w_instr[31:24] == c_op_bc) begin
            w_dec.br_cond   = 1'b1;
            w_dec.cond      = w_instr[3:0];
            w_dec.br_offset = {{(XLEN-21){w_instr[23]}}, w_instr[23:5], 2'b00};
        end else if (w_instr[31:24] == c_op_cbz) begin
            w_dec.br_zero   = 1'b1;
            w_dec.rm        = w_instr[4:0];
            w_dec.br_offset = {{(XLEN-21){w_instr[23]}}, w_instr[23:5], 2'b00};
            w_use_rm        = 1'b1;
        end else begin
            w_dec.illegal = 1'b1;
        end
    end

    // XZR (register 31) is never a real producer, so it cannot create a hazard
    assign w_hazard = r_valid && r_is_ldur && (r_dec.rd != 5'd31) && bus.in_valid &&
                      ((w_use_rn && (w_dec.rn == r_dec.rd)) ||
                       (w_use_rm && (w_dec.rm == r_dec.rd)));

    assign w_in_ready = rst && !bus.flush && !w_hazard && (!r_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_is_ldur <= 1'b0;
            r_pc      <= '0;
            r_dec     <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_is_ldur <= w_is_ldur;
            r_pc      <= bus.in_pc;
            r_dec     <= w_dec;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.out_pc     = r_pc;
    assign bus.rd         = r_dec.rd;
    assign bus.rn         = r_dec.rn;
    assign bus.rm         = r_dec.rm;
    assign bus.reg_write  = r_dec.reg_write;
    assign bus.mem_write  = r_dec.mem_write;
    assign bus.mem_to_reg = r_dec.mem_to_reg;
    assign bus.alu_src    = r_dec.alu_src;
    assign bus.set_flags  = r_dec.set_flags;
    assign bus.alu_op     = r_dec.alu_op;
    assign bus.uncond_br  = r_dec.uncond_br;
    assign bus.br_zero    = r_dec.br_zero;
    assign bus.br_cond    = r_dec.br_cond;
    assign bus.cond       = r_dec.cond;
    assign bus.illegal    = r_dec.illegal;
    assign bus.imm        = r_dec.imm;
    assign bus.br_offset  = r_dec.br_offset;
endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// tb_decode_stage
// Table-driven scoreboard bench for decode_stage, plus hazard/stall/flush/reset sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        set_flags;
        logic [2:0]  alu_op;
        logic        uncond_br;
        logic        br_zero;
        logic        br_cond;
        logic [3:0]  cond;
        logic        illegal;
        logic [63:0] imm;
        logic [63:0] br_offset;
        logic [63:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(64), .PC_W(64)) bus ();

    decode_stage #(.XLEN(64), .PC_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t cur_exp;
    logic last_acc;
    vec_t vec[14];

    function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                                input logic rw, input logic mw, input logic mtr, input logic as,
                                input logic sf, input logic [2:0] op, input logic ub, input logic bz,
                                input logic bc, input logic [3:0] cd, input logic ill,
                                input logic [63:0] imm, input logic [63:0] bro);
        exp_t e;
        e = '0;
        e.rd = rd; e.rn = rn; e.rm = rm;
        e.reg_write = rw; e.mem_write = mw; e.mem_to_reg = mtr; e.alu_src = as;
        e.set_flags = sf; e.alu_op = op;
        e.uncond_br = ub; e.br_zero = bz; e.br_cond = bc; e.cond = cd; e.illegal = ill;
        e.imm = imm; e.br_offset = bro;
        return e;
    endfunction

    function automatic exp_t got();
        exp_t g;
        g.rd = bus.rd; g.rn = bus.rn; g.rm = bus.rm;
        g.reg_write = bus.reg_write; g.mem_write = bus.mem_write;
        g.mem_to_reg = bus.mem_to_reg; g.alu_src = bus.alu_src;
        g.set_flags = bus.set_flags; g.alu_op = bus.alu_op;
        g.uncond_br = bus.uncond_br; g.br_zero = bus.br_zero; g.br_cond = bus.br_cond;
        g.cond = bus.cond; g.illegal = bus.illegal;
        g.imm = bus.imm; g.br_offset = bus.br_offset; g.pc = bus.out_pc;
        return g;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic chk_rec(input string name, input exp_t act, input exp_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // One clock: observe the handshakes mid-cycle, then step past the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = bus.in_valid && bus.in_ready;
        if (!rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.flush) begin
                if (q.size() > 0) e = q.pop_front();
            end else if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk_rec("output_record", got(), e);
                end
            end
            if (last_acc) q.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input exp_t e, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        cur_exp      = e;
        cur_exp.pc   = pc;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        vec[0]  = '{32'h91000401, mk(1, 0, 0, 1,0,0,1,0, 3'b010, 0,0,0, 4'd0, 0, 64'd1, 64'd0)};
        vec[1]  = '{32'hAB040043, mk(3, 2, 4, 1,0,0,0,1, 3'b010, 0,0,0, 4'd0, 0, 64'd0, 64'd0)};
        vec[2]  = '{32'hEB0700C5, mk(5, 6, 7, 1,0,0,0,1, 3'b011, 0,0,0, 4'd0, 0, 64'd0, 64'd0)};
        vec[3]  = '{32'hD3600C41, mk(1, 2, 0, 1,0,0,1,0, 3'b101, 0,0,0, 4'd0, 0, 64'd3, 64'd0)};
        vec[4]  = '{32'hD340FCA4, mk(4, 5, 0, 1,0,0,1,0, 3'b110, 0,0,0, 4'd0, 0, 64'd63, 64'd0)};
        vec[5]  = '{32'hF85F8022, mk(2, 1, 31, 1,0,1,1,0, 3'b010, 0,0,0, 4'd0, 0,
                                     64'hFFFF_FFFF_FFFF_FFF8, 64'd0)};
        vec[6]  = '{32'hF8010069, mk(9, 3, 9, 0,1,0,1,0, 3'b010, 0,0,0, 4'd0, 0, 64'd16, 64'd0)};
        vec[7]  = '{32'h17FFFFFF, mk(31, 31, 31, 0,0,0,0,0, 3'b000, 1,0,0, 4'd0, 0, 64'd0,
                                     64'hFFFF_FFFF_FFFF_FFFC)};
        vec[8]  = '{32'h54000041, mk(1, 2, 0, 0,0,0,0,0, 3'b000, 0,0,1, 4'd1, 0, 64'd0, 64'd8)};
        vec[9]  = '{32'hB4FFFFE7, mk(7, 31, 7, 0,0,0,0,0, 3'b000, 0,1,0, 4'd0, 0, 64'd0,
                                     64'hFFFF_FFFF_FFFF_FFFC)};
`ifdef DECODE_MUL_EN
        vec[10] = '{32'h9B047C43, mk(3, 2, 4, 1,0,0,0,0, 3'b111, 0,0,0, 4'd0, 0, 64'd0, 64'd0)};
`else
        vec[10] = '{32'h9B047C43, mk(3, 2, 4, 0,0,0,0,0, 3'b000, 0,0,0, 4'd0, 1, 64'd0, 64'd0)};
`endif
        vec[11] = '{32'h00000000, mk(0, 0, 0, 0,0,0,0,0, 3'b000, 0,0,0, 4'd0, 1, 64'd0, 64'd0)};
        vec[12] = '{32'hF84FF3FF, mk(31, 31, 15, 1,0,1,1,0, 3'b010, 0,0,0, 4'd0, 0, 64'd255, 64'd0)};
        vec[13] = '{32'h913FFFFF, mk(31, 31, 31, 1,0,0,1,0, 3'b010, 0,0,0, 4'd0, 0, 64'd4095, 64'd0)};

        rst = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.out_ready = 1'b0;
        cur_exp = '0;
        last_acc = 1'b0;
        tick(); tick();
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
        chk_rec("reset_fields", got(), '0);
        rst = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Stream the table with random backpressure
        for (int i = 0; i < 14; i++) begin
            drive(vec[i].instr, vec[i].exp, 64'h1000 + 64'(i) * 4);
            n = 0;
            do begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end while (!last_acc && n < 30);
            if (!last_acc) chk("accept_timeout", 64'd1, 64'd0);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 30) begin
            bus.out_ready = 1'b1;
            tick();
            n++;
        end
        chk("table_drain", 64'(q.size()), 64'd0);
        tick();
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Load-use: LDUR X2 then ADDS X3,X2,X4 costs exactly one bubble
        bus.out_ready = 1'b1;
        drive(vec[5].instr, vec[5].exp, 64'h2000);
        tick();
        chk("ldur_accepted", 64'(last_acc), 64'd1);
        drive(vec[1].instr, vec[1].exp, 64'h2004);
        chk("hazard_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("hazard_no_accept", 64'(last_acc), 64'd0);
        chk("bubble_out_valid", 64'(bus.out_valid), 64'd0);
        chk("after_bubble_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("dependent_accepted", 64'(last_acc), 64'd1);
        bus.in_valid = 1'b0;
        chk("dependent_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        chk("hazard_drain", 64'(q.size()), 64'd0);

        // Hazard source selection: B.cond ignores rn, CBZ reads Rt, XZR never stalls
        drive(vec[5].instr, vec[5].exp, 64'h2100);
        tick();
        drive(32'h54000041, vec[8].exp, 64'h2104);
        chk("bcond_no_hazard", 64'(bus.in_ready), 64'd1);
        drive(32'hB4FFFFE2, vec[9].exp, 64'h2104);
        chk("cbz_rt_hazard", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        tick();
        drive(vec[12].instr, vec[12].exp, 64'h2200);
        tick();
        drive(vec[13].instr, vec[13].exp, 64'h2204);
        chk("xzr_no_hazard", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("xzr_drain", 64'(q.size()), 64'd0);

        // Hold ADDI under backpressure, then flush it
        bus.out_ready = 1'b0;
        drive(vec[0].instr, vec[0].exp, 64'h3000);
        tick();
        e = vec[0].exp;
        e.pc = 64'h3000;
        drive(vec[2].instr, vec[2].exp, 64'h3004);
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk_rec("stall_fields", got(), e);
            tick();
        end
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_dropped", 64'(q.size()), 64'd0);
        bus.in_valid = 1'b0;

        // Reset while stalled
        drive(vec[0].instr, vec[0].exp, 64'h4000);
        tick();
        bus.in_valid = 1'b0;
        chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk_rec("rst_fields", got(), '0);
        tick();
        chk("rst_hold_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_release_in_ready", 64'(bus.in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
